// File: rtl/ifu_iccm_dma_arb_if.sv
// rtl/ifu_iccm_dma_arb_if.sv - DMA, fetch-status and debug signals of the ICCM port arbiter
interface ifu_iccm_dma_arb_if #(
  parameter int TAG_W = 3
);
  logic             dma_iccm_req;
  logic             dma_iccm_wr;
  logic [TAG_W-1:0] dma_iccm_tag;
  logic             ifc_dma_access_ok;
  logic             ifc_fetch_req_f1;
  logic             ifc_iccm_access_f1;
  logic             dec_tlu_dbg_halted;
  logic             dma_iccm_gnt;
  logic             iccm_sel_dma;
  logic             dma_iccm_stall_any;
  logic             iccm_dma_rvalid;
  logic [TAG_W-1:0] iccm_dma_rtag;
  logic [1:0]       arb_state;
  logic [15:0]      dma_wait_cycles;
  logic             dma_force_evt;

  modport master (
    output dma_iccm_req, dma_iccm_wr, dma_iccm_tag, ifc_dma_access_ok,
           ifc_fetch_req_f1, ifc_iccm_access_f1, dec_tlu_dbg_halted,
    input  dma_iccm_gnt, iccm_sel_dma, dma_iccm_stall_any, iccm_dma_rvalid,
           iccm_dma_rtag, arb_state, dma_wait_cycles, dma_force_evt
  );

  modport slave (
    input  dma_iccm_req, dma_iccm_wr, dma_iccm_tag, ifc_dma_access_ok,
           ifc_fetch_req_f1, ifc_iccm_access_f1, dec_tlu_dbg_halted,
    output dma_iccm_gnt, iccm_sel_dma, dma_iccm_stall_any, iccm_dma_rvalid,
           iccm_dma_rtag, arb_state, dma_wait_cycles, dma_force_evt
  );
endinterface

// File: rtl/ifu_iccm_dma_arb.sv
// rtl/ifu_iccm_dma_arb.sv - ICCM port arbiter between instruction fetch and the DMA slave
// Perf counters (dma_wait_cycles, dma_force_evt) are built only with RV_ICCM_ARB_PERF_EN.
module ifu_iccm_dma_arb #(
  parameter int MAX_WAIT  = 16,
  parameter int DMA_BURST = 4,
  parameter int RD_LAT    = 2,
  parameter int TAG_W     = 3
) (
  input  logic              clk,
  input  logic              rst_l,
  ifu_iccm_dma_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, FORCE = 2'b10, DMA = 2'b11} state_e;

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int BCW = $clog2(DMA_BURST + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MAX_WAIT - 1);
  localparam logic [WCW-1:0] WAIT_MAX   = WCW'(MAX_WAIT);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(DMA_BURST - 1);
  localparam logic [BCW-1:0] BURST_MAX  = BCW'(DMA_BURST);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [BCW-1:0]   burst_q, burst_d;
  logic             ok_eff, fetch_pend, gnt;
  logic [RD_LAT-1:0] rd_vld_q;
  logic [TAG_W-1:0] rd_tag_q [RD_LAT];

  assign ok_eff     = bus.ifc_dma_access_ok | bus.dec_tlu_dbg_halted;
  assign fetch_pend = bus.ifc_fetch_req_f1 & bus.ifc_iccm_access_f1;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dma_iccm_req) begin
          if (ok_eff) begin
            state_d = DMA;
          end else begin
            state_d = WAIT;
            wait_d  = '0;
          end
        end
      end
      WAIT: begin
        if (!bus.dma_iccm_req)      state_d = IDLE;
        else if (ok_eff)            state_d = DMA;
        else if (wait_q == WAIT_LAST) state_d = FORCE;
        else if (wait_q != WAIT_MAX)  wait_d = wait_q + 1'b1;
      end
      // The fetch controller sees the stall one cycle late, so FORCE holds it off before the mux flips.
      FORCE: state_d = DMA;
      DMA: begin
        gnt = bus.dma_iccm_req;
        if (!bus.dma_iccm_req) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (burst_q == BURST_LAST) begin
          burst_d = '0;
          if (fetch_pend && !bus.dec_tlu_dbg_halted) begin
            state_d = WAIT;
            wait_d  = '0;
          end
        end else if (burst_q != BURST_MAX) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_tag_q[i] <= '0;
    end else begin
      rd_vld_q[0] <= gnt & ~bus.dma_iccm_wr;
      rd_tag_q[0] <= bus.dma_iccm_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_tag_q[i] <= rd_tag_q[i-1];
      end
    end
  end

  assign bus.dma_iccm_gnt       = gnt;
  assign bus.iccm_sel_dma       = (state_q == DMA);
  assign bus.dma_iccm_stall_any = (state_q == FORCE) || (state_q == DMA);
  assign bus.arb_state          = state_q;
  assign bus.iccm_dma_rvalid    = rd_vld_q[RD_LAT-1];
  assign bus.iccm_dma_rtag      = rd_vld_q[RD_LAT-1] ? rd_tag_q[RD_LAT-1] : '0;

`ifdef RV_ICCM_ARB_PERF_EN
  logic [15:0] wait_cyc_q;
  logic        force_evt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wait_cyc_q  <= '0;
      force_evt_q <= 1'b0;
    end else begin
      if (((state_q == WAIT) || (state_q == FORCE)) && (wait_cyc_q != 16'hFFFF))
        wait_cyc_q <= wait_cyc_q + 16'd1;
      force_evt_q <= (state_q == WAIT) && (state_d == FORCE);
    end
  end

  assign bus.dma_wait_cycles = wait_cyc_q;
  assign bus.dma_force_evt   = force_evt_q;
`else
  assign bus.dma_wait_cycles = '0;
  assign bus.dma_force_evt   = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_iccm_dma_arb.sv
// tb/tb_ifu_iccm_dma_arb.sv - self-checking bench for the ICCM fetch/DMA arbiter
module tb_ifu_iccm_dma_arb;
  localparam int MAX_WAIT  = 16;
  localparam int DMA_BURST = 4;
  localparam int RD_LAT    = 2;
  localparam int TAG_W     = 3;
  localparam logic [1:0] S_IDLE = 2'b00, S_WAIT = 2'b01, S_FORCE = 2'b10, S_DMA = 2'b11;
`ifdef RV_ICCM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   due_q[$];
  logic [TAG_W-1:0] tag_q[$];

  ifu_iccm_dma_arb_if #(.TAG_W(TAG_W)) bus ();

  ifu_iccm_dma_arb #(
    .MAX_WAIT(MAX_WAIT), .DMA_BURST(DMA_BURST), .RD_LAT(RD_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_l(rst_l), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dma_iccm_req       = 1'b0;
    bus.dma_iccm_wr        = 1'b0;
    bus.dma_iccm_tag       = '0;
    bus.ifc_dma_access_ok  = 1'b0;
    bus.ifc_fetch_req_f1   = 1'b0;
    bus.ifc_iccm_access_f1 = 1'b0;
    bus.dec_tlu_dbg_halted = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.arb_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", bus.arb_state, S_IDLE);
    end
    checks++;
    if ({bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any, bus.iccm_dma_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000",
        {bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any, bus.iccm_dma_rvalid});
    end
    checks++;
    if ({bus.iccm_dma_rtag, bus.dma_wait_cycles, bus.dma_force_evt} !== '0) begin
      errors++; $display("FAIL reset_data: got rtag %0d wait %0d evt %0d expected all 0",
        bus.iccm_dma_rtag, bus.dma_wait_cycles, bus.dma_force_evt);
    end
    next_cycle();
    rst_l = 1'b1;
    next_cycle();
  endtask

  task automatic test_forced_stall();
    int n_wait = 0;
    int wait_bad = 0;
    int evts = 0;
    bit done = 1'b0;
    bus.dma_iccm_req = 1'b1; bus.dma_iccm_wr = 1'b1;
    bus.dma_iccm_tag = TAG_W'($urandom); bus.ifc_dma_access_ok = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.arb_state, bus.dma_iccm_stall_any} !== {S_IDLE, 1'b0}) begin
      errors++; $display("FAIL force_start: got state %0d stall %0d expected 0 0", bus.arb_state, bus.dma_iccm_stall_any);
    end
    next_cycle();
    for (int i = 0; i < MAX_WAIT + 8 && !done; i++) begin
      @(negedge clk);
      if (bus.dma_force_evt) evts++;
      if (bus.arb_state == S_WAIT) begin
        n_wait++;
        if ({bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any} != 3'b000) wait_bad++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (n_wait !== MAX_WAIT) begin
      errors++; $display("FAIL force_wait_len: got %0d expected %0d", n_wait, MAX_WAIT);
    end
    checks++;
    if (wait_bad !== 0) begin
      errors++; $display("FAIL force_wait_outputs: got %0d bad cycles expected 0", wait_bad);
    end
    checks++;
    if ({bus.arb_state, bus.dma_iccm_stall_any, bus.dma_iccm_gnt, bus.iccm_sel_dma} !== {S_FORCE, 3'b100}) begin
      errors++; $display("FAIL force_state: got %b expected %b",
        {bus.arb_state, bus.dma_iccm_stall_any, bus.dma_iccm_gnt, bus.iccm_sel_dma}, {S_FORCE, 3'b100});
    end
    next_cycle();
    @(negedge clk);
    if (bus.dma_force_evt) evts++;
    checks++;
    if ({bus.arb_state, bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any} !== {S_DMA, 3'b111}) begin
      errors++; $display("FAIL force_to_dma: got %b expected %b",
        {bus.arb_state, bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any}, {S_DMA, 3'b111});
    end
    checks++;
    if (bus.dma_wait_cycles !== (PERF ? 16'd17 : 16'd0)) begin
      errors++; $display("FAIL perf_wait_cycles: got %0d expected %0d", bus.dma_wait_cycles, PERF ? 17 : 0);
    end
    checks++;
    if (evts !== (PERF ? 1 : 0)) begin
      errors++; $display("FAIL perf_force_evt: got %0d pulses expected %0d", evts, PERF ? 1 : 0);
    end
    next_cycle();
    bus.dma_iccm_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_idle_grant();
    bus.dma_iccm_req = 1'b1; bus.dma_iccm_wr = 1'b0;
    bus.dma_iccm_tag = 3'd5; bus.ifc_dma_access_ok = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.arb_state, bus.dma_iccm_gnt} !== {S_IDLE, 1'b0}) begin
      errors++; $display("FAIL idle_pre: got state %0d gnt %0d expected 0 0", bus.arb_state, bus.dma_iccm_gnt);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.arb_state, bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any} !== {S_DMA, 3'b111}) begin
      errors++; $display("FAIL idle_grant: got %b expected %b",
        {bus.arb_state, bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any}, {S_DMA, 3'b111});
    end
    next_cycle();
    bus.dma_iccm_req = 1'b0; bus.dma_iccm_tag = '0;
    @(negedge clk);
    checks++;
    if ({bus.dma_iccm_gnt, bus.iccm_dma_rvalid} !== 2'b00) begin
      errors++; $display("FAIL idle_gnt1: got gnt %0d rvalid %0d expected 0 0", bus.dma_iccm_gnt, bus.iccm_dma_rvalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.iccm_dma_rvalid, bus.iccm_dma_rtag, bus.arb_state} !== {1'b1, 3'd5, S_IDLE}) begin
      errors++; $display("FAIL idle_rdata: got rvalid %0d rtag %0d state %0d expected 1 5 0",
        bus.iccm_dma_rvalid, bus.iccm_dma_rtag, bus.arb_state);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.iccm_dma_rvalid !== 1'b0) begin
      errors++; $display("FAIL idle_rvalid_end: got %0d expected 0", bus.iccm_dma_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_burst_limit();
    int n = 0;
    int n2 = 0;
    bit done = 1'b0;
    bus.dma_iccm_req = 1'b1; bus.dma_iccm_wr = 1'b1; bus.ifc_dma_access_ok = 1'b1;
    bus.ifc_fetch_req_f1 = 1'b1; bus.ifc_iccm_access_f1 = 1'b1;
    next_cycle();
    bus.ifc_dma_access_ok = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.dma_iccm_gnt) begin
        n++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (n !== DMA_BURST) begin
      errors++; $display("FAIL burst_len: got %0d grants expected %0d", n, DMA_BURST);
    end
    checks++;
    if ({bus.arb_state, bus.dma_iccm_stall_any, bus.iccm_sel_dma} !== {S_WAIT, 2'b00}) begin
      errors++; $display("FAIL burst_yield: got state %0d stall %0d sel %0d expected 1 0 0",
        bus.arb_state, bus.dma_iccm_stall_any, bus.iccm_sel_dma);
    end
    next_cycle();
    bus.ifc_fetch_req_f1 = 1'b0; bus.ifc_iccm_access_f1 = 1'b0; bus.ifc_dma_access_ok = 1'b1;
    next_cycle();
    bus.ifc_dma_access_ok = 1'b0;
    for (int i = 0; i < 3 * DMA_BURST; i++) begin
      @(negedge clk);
      if (bus.dma_iccm_gnt && bus.arb_state == S_DMA) n2++;
      next_cycle();
    end
    checks++;
    if (n2 !== 3 * DMA_BURST) begin
      errors++; $display("FAIL burst_no_fetch: got %0d grants expected %0d", n2, 3 * DMA_BURST);
    end
    bus.dma_iccm_req = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.arb_state !== S_IDLE) begin
      errors++; $display("FAIL burst_release: got %0d expected %0d", bus.arb_state, S_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_halt_bypass();
    bus.dma_iccm_req = 1'b1; bus.dma_iccm_wr = 1'b1;
    bus.ifc_dma_access_ok = 1'b0; bus.dec_tlu_dbg_halted = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.arb_state, bus.dma_iccm_gnt} !== {S_DMA, 1'b1}) begin
      errors++; $display("FAIL halt_idle_bypass: got state %0d gnt %0d expected 3 1", bus.arb_state, bus.dma_iccm_gnt);
    end
    next_cycle();
    bus.dma_iccm_req = 1'b0; bus.dec_tlu_dbg_halted = 1'b0;
    next_cycle();
    bus.dma_iccm_req = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.arb_state !== S_WAIT) begin
      errors++; $display("FAIL halt_wait_pre: got %0d expected %0d", bus.arb_state, S_WAIT);
    end
    next_cycle();
    bus.dec_tlu_dbg_halted = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.arb_state !== S_DMA) begin
      errors++; $display("FAIL halt_wait_bypass: got %0d expected %0d", bus.arb_state, S_DMA);
    end
    next_cycle();
    bus.dma_iccm_req = 1'b0; bus.dec_tlu_dbg_halted = 1'b0;
    next_cycle();
  endtask

  task automatic test_pipelined_reads();
    bit op_wr [8];
    logic [TAG_W-1:0] op_tag [8];
    logic exp_v;
    logic [TAG_W-1:0] exp_t;
    int bad = 0;
    op_wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    op_tag = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    op_tag[4] = TAG_W'($urandom);
    op_tag[7] = TAG_W'($urandom);
    due_q.delete(); tag_q.delete();
    bus.dma_iccm_req = 1'b1; bus.dma_iccm_wr = 1'b1; bus.ifc_dma_access_ok = 1'b1;
    next_cycle();
    for (int k = 0; k < 8 + RD_LAT + 1; k++) begin
      if (k < 8) begin
        bus.dma_iccm_wr = op_wr[k]; bus.dma_iccm_tag = op_tag[k];
      end else begin
        bus.dma_iccm_req = 1'b0; bus.dma_iccm_wr = 1'b0;
      end
      @(negedge clk);
      if (bus.dma_iccm_gnt !== (k < 8)) bad++;
      exp_v = 1'b0; exp_t = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_v = 1'b1; exp_t = tag_q[0];
        void'(due_q.pop_front()); void'(tag_q.pop_front());
      end
      checks++;
      if (bus.iccm_dma_rvalid !== exp_v || (exp_v && bus.iccm_dma_rtag !== exp_t)) begin
        errors++; $display("FAIL pipe_read k=%0d: got rvalid %0d rtag %0d expected %0d %0d",
          k, bus.iccm_dma_rvalid, bus.iccm_dma_rtag, exp_v, exp_t);
      end
      if (k < 8 && !op_wr[k]) begin
        due_q.push_back(cyc + RD_LAT); tag_q.push_back(op_tag[k]);
      end
      next_cycle();
    end
    checks++;
    if (bad !== 0 || due_q.size() !== 0) begin
      errors++; $display("FAIL pipe_grants: got %0d bad grants %0d unreturned expected 0 0", bad, due_q.size());
    end
  endtask

  task automatic test_random();
    bit in_dma = 1'b0;
    bit hold = 1'b0;
    bit fp, exp_g;
    int run = 0;
    logic exp_v;
    logic [TAG_W-1:0] exp_t;
    due_q.delete(); tag_q.delete();
    bus.ifc_dma_access_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!hold) begin
        bus.dma_iccm_req = ($urandom_range(0, 3) != 0);
        bus.dma_iccm_wr  = 1'($urandom);
        bus.dma_iccm_tag = TAG_W'($urandom);
      end
      bus.ifc_fetch_req_f1   = 1'($urandom);
      bus.ifc_iccm_access_f1 = 1'($urandom);
      fp = bus.ifc_fetch_req_f1 & bus.ifc_iccm_access_f1;
      @(negedge clk);
      exp_g = in_dma & bus.dma_iccm_req;
      checks++;
      if ({bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any} !== {exp_g, in_dma, in_dma}) begin
        errors++; $display("FAIL rand_ctrl i=%0d: got %b expected %b", i,
          {bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any}, {exp_g, in_dma, in_dma});
      end
      exp_v = 1'b0; exp_t = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_v = 1'b1; exp_t = tag_q[0];
        void'(due_q.pop_front()); void'(tag_q.pop_front());
      end
      checks++;
      if (bus.iccm_dma_rvalid !== exp_v || (exp_v && bus.iccm_dma_rtag !== exp_t)) begin
        errors++; $display("FAIL rand_read i=%0d: got rvalid %0d rtag %0d expected %0d %0d",
          i, bus.iccm_dma_rvalid, bus.iccm_dma_rtag, exp_v, exp_t);
      end
      if (exp_g && !bus.dma_iccm_wr) begin
        due_q.push_back(cyc + RD_LAT); tag_q.push_back(bus.dma_iccm_tag);
      end
      if (exp_g) begin
        run++;
        if (run == DMA_BURST) begin
          run = 0;
          in_dma = !fp;
        end
      end else begin
        run = 0;
        in_dma = bus.dma_iccm_req;
      end
      hold = bus.dma_iccm_req & ~exp_g;
      next_cycle();
    end
    idle_inputs();
    repeat (RD_LAT + 2) next_cycle();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    bus.dma_iccm_req = 1'b1; bus.dma_iccm_wr = 1'b0;
    bus.ifc_dma_access_ok = 1'b1; bus.dma_iccm_tag = 3'd6;
    next_cycle();
    next_cycle();
    bus.dma_iccm_tag = 3'd7;
    next_cycle();
    rst_l = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({bus.arb_state, bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any, bus.iccm_dma_rvalid} !== 6'b0) begin
      errors++; $display("FAIL async_reset: got %b expected 000000",
        {bus.arb_state, bus.dma_iccm_gnt, bus.iccm_sel_dma, bus.dma_iccm_stall_any, bus.iccm_dma_rvalid});
    end
    checks++;
    if ({bus.iccm_dma_rtag, bus.dma_wait_cycles, bus.dma_force_evt} !== '0) begin
      errors++; $display("FAIL async_reset_data: got rtag %0d wait %0d evt %0d expected all 0",
        bus.iccm_dma_rtag, bus.dma_wait_cycles, bus.dma_force_evt);
    end
    next_cycle();
    rst_l = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      if (bus.iccm_dma_rvalid !== 1'b0 || bus.arb_state !== S_IDLE) bad++;
      next_cycle();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_flush: got %0d cycles with rvalid or non-idle expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_forced_stall();
    test_idle_grant();
    test_burst_limit();
    test_halt_bypass();
    test_pipelined_reads();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
